line_readout_packer: RTL and testbench
======================================

// Module: line_readout_packer
// PURPOSE
//  Downstream consumer of the ping-pong line buffer. On each completed line, generates the
//  pixel read addresses (PIX_OUT), absorbs the buffer's fixed read latency, and streams
//  one header word plus PIX_IN_ROW pixel words to the host interface.
//  Uses a valid/ready handshake with full backpressure. Runs in the buffer's read-side clock domain.
// PARAMETERS
//  ADC_WIDHT   14   sample width; from define.v
//  PIX_IN_ROW  320  pixels per line; from define.v
//  ROWS        240  lines per frame; line number wraps to 0 after ROWS-1
//  RD_LAT      2    cycles from PIX_OUT change to matching DATA_IN on the buffer port
//  FIFO_DEPTH  4    return-data FIFO entries; must be >= RD_LAT+1
// PORTS
//  CLK          in   1          read-side clock, all logic on posedge
//  RESET        in   1          asynchronous, active-high
//  FRAME_START  in   1          1-cycle pulse; clears line number
//  LINE_READY   in   1          1-cycle pulse; a full line is readable in the buffer
//  PIX_OUT      out  10         pixel read address to line buffer
//  DATA_IN      in   ADC_WIDHT  buffer read data, valid RD_LAT cycles after address
//  OUT_DATA     out  16         stream word
//  OUT_VALID    out  1          OUT_DATA valid
//  OUT_READY    in   1          sink accepts word when OUT_VALID&&OUT_READY
//  BUSY         out  1          line transfer in progress
//  LINE_DONE    out  1          1-cycle pulse after last pixel word accepted
//  OVERRUN      out  1          1-cycle pulse: LINE_READY arrived while BUSY
// BEHAVIOUR
//  Reset: PIX_OUT=0, OUT_DATA=0, OUT_VALID=0, BUSY=0, LINE_DONE=0, OVERRUN=0, line_num=0,
//   FIFO empty, in-flight count 0, state IDLE. Reset mid-line abandons the line; no partial drain.
//  FSM: IDLE -> HDR on LINE_READY. HDR -> PIX when header accepted.
//   PIX -> IDLE when the PIX_IN_ROW-th pixel word is accepted (LINE_DONE=1 that cycle+1).
//  HDR: OUT_DATA={4'hA,2'b00,line_num[9:0]}, OUT_VALID=1; held stable until OUT_READY.
//   Address issue starts in HDR, so prefetch overlaps the header.
//  Address issue: addr counter 0..PIX_IN_ROW-1 drives PIX_OUT. It advances only when
//   fifo_count + inflight < FIFO_DEPTH. A delay line of RD_LAT tag bits marks which DATA_IN
//   cycles carry a requested sample, and those samples are pushed to the FIFO.
//   PIX_OUT holds the last address after issue completes.
//  Pixel words: OUT_DATA={2'b00,DATA_IN sample}, taken from the FIFO head.
//   OUT_VALID=1 whenever the FIFO is non-empty in PIX. Word and valid stay stable until accepted.
//   Pop and push in the same cycle are both honoured. FIFO never overflows (credit rule);
//   overflow is an assertion failure.
//  Output is registered: OUT_DATA/OUT_VALID change only on CLK edge. Back-to-back acceptance
//   with OUT_READY held high gives 1 word/cycle.
//  BUSY=1 from the cycle after LINE_READY until the cycle LINE_DONE pulses (inclusive of neither).
//  line_num: increments (mod ROWS) on LINE_DONE. FRAME_START forces 0.
//   If FRAME_START and LINE_DONE coincide, the result is 0.
//   FRAME_START together with LINE_READY in IDLE gives header line_num=0.
//   FRAME_START while BUSY does not alter the header already emitted.
//  LINE_READY while BUSY: ignored, OVERRUN pulses next cycle. Current line is unaffected.
//   LINE_READY in the same cycle as LINE_DONE counts as BUSY (overrun).
//  OUT_READY may toggle arbitrarily. OUT_READY=0 indefinitely stalls address issue once credits
//   are exhausted, with no data loss.
// STRUCTURE
//  define.v gains ROWS, HDR_TAG (4'hA) and RD_LAT alongside ADC_WIDHT/PIX_IN_ROW.
//  One sub-module: line_rd_fifo (sync FIFO, FIFO_DEPTH x ADC_WIDHT, count output,
//   async active-high reset).
//  Top holds the FSM, address/credit counter, RD_LAT tag shift register, line_num and output register.
// TESTING
//  Buffer model returns DATA_IN = addr+100 after RD_LAT=2.
//  1. Reset, FRAME_START, LINE_READY, OUT_READY=1 ->
//     header 16'hA000, then words 100..419 consecutive, LINE_DONE once, BUSY low after.
//  2. Three LINE_READY pulses, one per completed line ->
//     headers A000, A001, A002. With ROWS=3, the 4th header is A000 (wrap).
//  3. OUT_READY random 30% ->
//     identical word sequence to test 1, FIFO count never >4, OUT_DATA stable while stalled.
//  4. OUT_READY=0 for 50 cycles in PIX ->
//     at most 4 addresses beyond the last accepted; the stream resumes intact.
//  5. LINE_READY mid-line -> OVERRUN one cycle, stream still 321 words.
//     FRAME_START mid-line -> next header A000.
//  6. RESET asserted at pixel 150 -> all outputs 0 immediately.
//     A new LINE_READY then yields a full clean line starting at header A000.

Source files
------------

// File: rtl/line_readout_packer_pkg.sv
// Shared constants, FSM encoding and helpers for the line readout packer.
package line_readout_packer_pkg;

  localparam int ADC_WIDHT   = 14;
  localparam int PIX_IN_ROW  = 320;
  localparam int DEF_ROWS    = 240;
  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int RD_LAT      = 2;   // the tag delay line below assumes RD_LAT >= 2
  localparam int FIFO_DEPTH  = 4;   // must cover RD_LAT+1 for full throughput
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX
  } state_t;

  // Number of set bits in the read-latency tag line (reads in flight).
  function automatic logic [CNT_W-1:0] count_ones(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/line_readout_packer_rd_fifo.sv
// Small synchronous FIFO that absorbs line-buffer return data until the sink takes it.
module line_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PUSH,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             POP,
  output logic [WIDTH-1:0] RD_DATA,
  output logic [CNT_W-1:0] COUNT
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = POP && (COUNT != '0);
  assign RD_DATA = mem[rd_ptr];

  // Storage array, no reset needed: COUNT qualifies every read.
  always_ff @(posedge CLK) begin
    if (PUSH) mem[wr_ptr] <= WR_DATA;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave COUNT unchanged.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (PUSH)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({PUSH, do_pop})
        2'b10:   COUNT <= COUNT + CNT_W'(1);
        2'b01:   COUNT <= COUNT - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // The upstream credit rule must never let a push land on a full FIFO.
  always_ff @(posedge CLK) begin
    if (!RESET && PUSH && !do_pop) assert (COUNT != CNT_W'(DEPTH));
  end

endmodule

// File: rtl/line_readout_packer.sv
// Reads a completed line out of the ping-pong buffer and streams header + pixels to the host.
module line_readout_packer
  import line_readout_packer_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FRAME_START,
  input  logic                 LINE_READY,
  output logic [9:0]           PIX_OUT,
  input  logic [ADC_WIDHT-1:0] DATA_IN,
  output logic [15:0]          OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 BUSY,
  output logic                 LINE_DONE,
  output logic                 OVERRUN
);

  // Stream handshake: a word transfers on a CLK edge where OUT_VALID && OUT_READY.
  // Once OUT_VALID is raised, OUT_DATA and OUT_VALID hold until that transfer happens.

  state_t                 state;
  logic [9:0]             line_num;
  logic                   fs_pend;
  logic [9:0]             issued;
  logic [9:0]             px_cnt;
  logic [15:0]            hdr_word;
  logic [RD_LAT-1:0]      tag;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W:0]         occupancy;
  logic [ADC_WIDHT-1:0]   fifo_head;
  logic                   issue_en;
  logic                   pop;
  logic                   last_pix;
  logic                   start;
  logic                   overrun_evt;

  // Credit check, handshake and line start/overrun decode.
  always_comb begin
    inflight    = count_ones(tag);
    occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
    issue_en    = (state != ST_IDLE) && (issued != 10'(PIX_IN_ROW)) &&
                  (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    pop         = (state == ST_PIX) && (fifo_count != '0) && OUT_READY;
    last_pix    = pop && (px_cnt == 10'(PIX_IN_ROW - 1));
    // The LINE_DONE cycle still belongs to the finished line, so a request there is an overrun.
    start       = LINE_READY && (state == ST_IDLE) && !LINE_DONE;
    overrun_evt = LINE_READY && !start;
  end

  // Stream word: header in HDR, FIFO head in PIX; all sources are registers.
  always_comb begin
    OUT_VALID = (state == ST_HDR) || ((state == ST_PIX) && (fifo_count != '0));
    OUT_DATA  = 16'h0000;
    if (state == ST_HDR)      OUT_DATA = hdr_word;
    else if (state == ST_PIX) OUT_DATA = {2'b00, fifo_head};
  end

  // Line FSM plus address issue; PIX_OUT is presented before it is counted as issued.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      LINE_DONE <= 1'b0;
      OVERRUN   <= 1'b0;
      PIX_OUT   <= '0;
      issued    <= '0;
      px_cnt    <= '0;
      hdr_word  <= '0;
      tag       <= '0;
    end else begin
      LINE_DONE <= 1'b0;
      OVERRUN   <= overrun_evt;
      tag       <= {tag[RD_LAT-2:0], issue_en};
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HDR;
            BUSY     <= 1'b1;
            PIX_OUT  <= '0;
            issued   <= '0;
            px_cnt   <= '0;
            hdr_word <= {HDR_TAG, 2'b00, (FRAME_START ? 10'd0 : line_num)};
          end
        end
        ST_HDR: begin
          if (OUT_READY) state <= ST_PIX;
        end
        ST_PIX: begin
          if (pop) px_cnt <= px_cnt + 10'd1;
          if (last_pix) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            LINE_DONE <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (issue_en) begin
        issued <= issued + 10'd1;
        if (issued != 10'(PIX_IN_ROW - 1)) PIX_OUT <= PIX_OUT + 10'd1;
      end
    end
  end

  // Line counter: a frame start during a line makes the following line number 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_num <= '0;
      fs_pend  <= 1'b0;
    end else if (FRAME_START) begin
      line_num <= '0;
      fs_pend  <= (state != ST_IDLE);
    end else if (LINE_DONE) begin
      line_num <= (fs_pend || (line_num == 10'(ROWS - 1))) ? 10'd0 : line_num + 10'd1;
      fs_pend  <= 1'b0;
    end
  end

  line_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADC_WIDHT),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .PUSH    (tag[RD_LAT-1]),
    .WR_DATA (DATA_IN),
    .POP     (pop),
    .RD_DATA (fifo_head),
    .COUNT   (fifo_count)
  );

endmodule

// File: tb/tb_line_readout_packer.sv
// Directed bench for line_readout_packer with a RD_LAT=2 line buffer model (data = addr+100).
module tb_line_readout_packer;
  import line_readout_packer_pkg::*;

  localparam int TB_ROWS = 3;

  logic                 CLK;
  logic                 RESET;
  logic                 FRAME_START;
  logic                 LINE_READY;
  logic [9:0]           PIX_OUT;
  logic [ADC_WIDHT-1:0] DATA_IN;
  logic [15:0]          OUT_DATA;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic                 BUSY;
  logic                 LINE_DONE;
  logic                 OVERRUN;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [9:0]  d1, d2;
  logic [15:0] got_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          ovr_cnt = 0;
  int          stall_viol = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [15:0] prev_d = '0;
  bit          ready_rand = 1'b0;

  line_readout_packer #(.ROWS(TB_ROWS)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FRAME_START (FRAME_START),
    .LINE_READY  (LINE_READY),
    .PIX_OUT     (PIX_OUT),
    .DATA_IN     (DATA_IN),
    .OUT_DATA    (OUT_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .BUSY        (BUSY),
    .LINE_DONE   (LINE_DONE),
    .OVERRUN     (OVERRUN)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Line buffer model: two-cycle read latency
  always @(posedge CLK) begin
    d1  <= PIX_OUT;
    d2  <= d1;
    cyc <= cyc + 1;
  end
  assign DATA_IN = 14'(d2) + 14'd100;

  // Monitor on the falling edge
  always @(negedge CLK) begin
    if (RESET) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r && (OUT_VALID !== 1'b1 || OUT_DATA !== prev_d)) stall_viol++;
      if (OUT_VALID && OUT_READY) begin
        got_q.push_back(OUT_DATA);
        cyc_q.push_back(cyc);
      end
      if (LINE_DONE) done_cnt++;
      if (OVERRUN) ovr_cnt++;
      prev_v = OUT_VALID;
      prev_r = OUT_READY;
      prev_d = OUT_DATA;
    end
  end

  // Random sink ready (70% high) when enabled
  initial forever begin
    @(posedge CLK);
    #1;
    if (ready_rand) OUT_READY = ($urandom_range(0, 9) >= 3);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_lr(input logic fs);
    tick();
    LINE_READY  = 1'b1;
    FRAME_START = fs;
    tick();
    LINE_READY  = 1'b0;
    FRAME_START = 1'b0;
  endtask

  task automatic pulse_fs();
    tick();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      tick();
      n++;
    end
    timed_out = (done_cnt == start_cnt);
  endtask

  task automatic wait_words(input int words, input int budget, output bit timed_out);
    int n;
    n = 0;
    while (got_q.size() < words && n < budget) begin
      tick();
      n++;
    end
    timed_out = (got_q.size() < words);
  endtask

  // Count of words differing from header + pixels 100..419
  function automatic int line_errors(input logic [15:0] hdr);
    int e;
    logic [15:0] w;
    if (got_q.size() != PIX_IN_ROW + 1) return 10000 + got_q.size();
    e = (got_q[0] !== hdr) ? 1 : 0;
    for (int i = 1; i <= PIX_IN_ROW; i++) begin
      w = 16'(i + 99);
      if (got_q[i] !== w) e++;
    end
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; FRAME_START = 1'b0; LINE_READY = 1'b0; OUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++; if (PIX_OUT !== 10'd0) $display("FAIL reset_pix_out: got %0h expected 0", PIX_OUT); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 16'h0) $display("FAIL reset_out_data: got %0h expected 0", OUT_DATA); else pass_cnt++;
    total_cnt++; if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", OUT_VALID); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", BUSY); else pass_cnt++;
    total_cnt++; if (LINE_DONE !== 1'b0) $display("FAIL reset_line_done: got %0b expected 0", LINE_DONE); else pass_cnt++;
    total_cnt++; if (OVERRUN !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", OVERRUN); else pass_cnt++;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_line();
    bit to;
    int d0;
    int span;
    got_q.delete(); cyc_q.delete();
    OUT_READY = 1'b1;
    d0 = done_cnt;
    pulse_lr(1'b1);
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL single_busy_high: got %0b expected 1", BUSY); else pass_cnt++;
    wait_done(2000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL single_timeout: got %0b expected 0", to); else pass_cnt++;
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL single_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
    span = (cyc_q.size() == PIX_IN_ROW + 1) ? cyc_q[PIX_IN_ROW] - cyc_q[1] : -1;
    total_cnt++; if (span !== PIX_IN_ROW - 1) $display("FAIL single_throughput: got %0d cycles expected %0d", span, PIX_IN_ROW - 1); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL single_busy_low: got %0b expected 0", BUSY); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (PIX_OUT !== 10'd319) $display("FAIL single_pix_hold: got %0d expected 319", PIX_OUT); else pass_cnt++;
    total_cnt++; if (OUT_VALID !== 1'b0) $display("FAIL single_idle_valid: got %0b expected 0", OUT_VALID); else pass_cnt++;
  endtask

  task automatic test_line_counter();
    bit to;
    logic [15:0] exp_hdr;
    logic [15:0] obs_hdr;
    OUT_READY = 1'b1;
    pulse_fs();
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      exp_hdr = (i == 3) ? 16'hA000 : 16'hA000 + 16'(i);
      pulse_lr(1'b0);
      wait_done(2000, to);
      total_cnt++; if (to !== 1'b0) $display("FAIL counter_timeout_%0d: got %0b expected 0", i, to); else pass_cnt++;
      obs_hdr = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
      total_cnt++; if (obs_hdr !== exp_hdr) $display("FAIL counter_header_%0d: got %0h expected %0h", i, obs_hdr, exp_hdr); else pass_cnt++;
      total_cnt++; if (line_errors(exp_hdr) !== 0) $display("FAIL counter_stream_%0d: got %0d bad words expected 0", i, line_errors(exp_hdr)); else pass_cnt++;
    end
  endtask

  task automatic test_random_ready();
    bit to;
    got_q.delete();
    stall_viol = 0;
    ready_rand = 1'b1;
    pulse_lr(1'b1);
    wait_done(6000, to);
    ready_rand = 1'b0;
    OUT_READY  = 1'b1;
    total_cnt++; if (to !== 1'b0) $display("FAIL random_timeout: got %0b expected 0", to); else pass_cnt++;
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL random_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
    total_cnt++; if (stall_viol !== 0) $display("FAIL random_stable: got %0d unstable stalls expected 0", stall_viol); else pass_cnt++;
  endtask

  task automatic test_stall();
    bit to;
    logic [9:0]  pix_a;
    logic [15:0] exp_head;
    int last_acc;
    int beyond;
    got_q.delete();
    OUT_READY = 1'b1;
    pulse_lr(1'b1);
    wait_words(100, 1000, to);
    OUT_READY = 1'b0;
    total_cnt++; if (to !== 1'b0) $display("FAIL stall_reach: got %0b expected 0", to); else pass_cnt++;
    repeat (10) tick();
    pix_a = PIX_OUT;
    repeat (40) tick();
    last_acc = int'(got_q[$]) - 100;
    // PIX_OUT is the next address to issue, so issued-but-unaccepted = PIX_OUT - (last_acc+1)
    beyond = int'(PIX_OUT) - (last_acc + 1);
    exp_head = got_q[$] + 16'd1;
    total_cnt++; if (PIX_OUT !== pix_a) $display("FAIL stall_pix_frozen: got %0d expected %0d", PIX_OUT, pix_a); else pass_cnt++;
    total_cnt++; if ((beyond <= 4) !== 1'b1) $display("FAIL stall_prefetch: got %0d expected at most 4", beyond); else pass_cnt++;
    total_cnt++; if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_head) $display("FAIL stall_head: got %0b/%0d expected 1/%0d", OUT_VALID, OUT_DATA, exp_head); else pass_cnt++;
    OUT_READY = 1'b1;
    wait_done(2000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL stall_timeout: got %0b expected 0", to); else pass_cnt++;
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL stall_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
  endtask

  task automatic test_overrun_frame();
    bit to;
    int o0;
    int n;
    logic [15:0] obs_hdr;
    got_q.delete();
    o0 = ovr_cnt;
    OUT_READY = 1'b1;
    pulse_lr(1'b1);
    wait_words(50, 1000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL ovr_reach: got %0b expected 0", to); else pass_cnt++;
    pulse_lr(1'b0);
    total_cnt++; if (OVERRUN !== 1'b1) $display("FAIL ovr_pulse: got %0b expected 1", OVERRUN); else pass_cnt++;
    tick();
    total_cnt++; if (OVERRUN !== 1'b0) $display("FAIL ovr_one_cycle: got %0b expected 0", OVERRUN); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL ovr_busy: got %0b expected 1", BUSY); else pass_cnt++;
    pulse_fs();
    n = 0;
    while (LINE_DONE !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    total_cnt++; if (LINE_DONE !== 1'b1) $display("FAIL ovr_done_seen: got %0b expected 1", LINE_DONE); else pass_cnt++;
    LINE_READY = 1'b1;
    @(posedge CLK);
    #1;
    LINE_READY = 1'b0;
    total_cnt++; if (OVERRUN !== 1'b1 || BUSY !== 1'b0) $display("FAIL ovr_at_done: got ovr=%0b busy=%0b expected ovr=1 busy=0", OVERRUN, BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL ovr_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
    total_cnt++; if (ovr_cnt - o0 !== 2) $display("FAIL ovr_count: got %0d expected 2", ovr_cnt - o0); else pass_cnt++;
    got_q.delete();
    pulse_lr(1'b0);
    wait_done(2000, to);
    obs_hdr = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    total_cnt++; if (obs_hdr !== 16'hA000) $display("FAIL fs_mid_header: got %0h expected a000", obs_hdr); else pass_cnt++;
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL fs_mid_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
  endtask

  task automatic test_reset_mid_line();
    bit to;
    logic [15:0] obs_hdr;
    got_q.delete();
    OUT_READY = 1'b1;
    pulse_lr(1'b0);
    wait_words(151, 1000, to);
    obs_hdr = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    total_cnt++; if (obs_hdr !== 16'hA001) $display("FAIL rst_pre_header: got %0h expected a001", obs_hdr); else pass_cnt++;
    RESET = 1'b1;
    #1;
    total_cnt++; if (PIX_OUT !== 10'd0) $display("FAIL rst_mid_pix_out: got %0h expected 0", PIX_OUT); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 16'h0) $display("FAIL rst_mid_out_data: got %0h expected 0", OUT_DATA); else pass_cnt++;
    total_cnt++; if (OUT_VALID !== 1'b0) $display("FAIL rst_mid_out_valid: got %0b expected 0", OUT_VALID); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL rst_mid_busy: got %0b expected 0", BUSY); else pass_cnt++;
    total_cnt++; if (LINE_DONE !== 1'b0 || OVERRUN !== 1'b0) $display("FAIL rst_mid_pulses: got %0b/%0b expected 0/0", LINE_DONE, OVERRUN); else pass_cnt++;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    got_q.delete();
    pulse_lr(1'b0);
    wait_done(2000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL rst_after_timeout: got %0b expected 0", to); else pass_cnt++;
    total_cnt++; if (line_errors(16'hA000) !== 0) $display("FAIL rst_after_stream: got %0d bad words expected 0", line_errors(16'hA000)); else pass_cnt++;
  endtask

  initial begin
    RESET = 1'b1; FRAME_START = 1'b0; LINE_READY = 1'b0; OUT_READY = 1'b0;
    test_reset();
    test_single_line();
    test_line_counter();
    test_random_ready();
    test_stall();
    test_overrun_frame();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
